guess_entry: RTL

GUESS_ENTRY -- requirements
Module: guess_entry

---
 rtl/guess_entry.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/guess_entry.sv
// guess_entry -- keypad-style entry buffer for a four-digit code guess.
//
// The user types up to four digits, may delete the last one or clear the
// whole entry, and commits a full entry with submit. A committed guess is
// held on `guess` (with a one-cycle guess_valid strobe) and the entry
// buffer freezes (LOCKED) until the next digit or clear starts a new entry.
//
// Ports
//   clk          rising-edge system clock
//   reset        asynchronous, active-high reset
//   enable       1 = entry pulses are honoured, 0 = every pulse is ignored
//   digit_valid  single-cycle pulse qualifying `digit`
//   digit[3:0]   digit value
//   del          single-cycle pulse: remove the last entered digit
//   submit       single-cycle pulse: commit the buffer as a guess
//   clear        single-cycle pulse: discard the partial entry
//   entry_buf    live entry, nibble 3 = first digit, unfilled nibble = 4'hF
//   digit_count  digits currently entered, 0..4
//   guess        last committed guess, same nibble order as entry_buf
//   guess_valid  one-cycle strobe: new guess on `guess`
//   entry_error  one-cycle strobe: the action of the previous edge was rejected
//   guess_count  committed guesses since reset, saturates at 255
//   dbg_state    current FSM state (0 = ENTRY, 1 = LOCKED)
//
// Input handshake: every input pulse is sampled on a single rising edge of
// clk while enable is high; there is no back-pressure. Per edge at most one
// action is taken, with priority clear > submit > del > digit_valid. The
// lower-priority pulses of that edge are dropped without an error.

module guess_entry #(
  parameter int ALLOW_REPEAT = 0,
  parameter int MAX_DIGIT    = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        del,
  input  logic        submit,
  input  logic        clear,
  output logic [15:0] entry_buf,
  output logic [2:0]  digit_count,
  output logic [15:0] guess,
  output logic        guess_valid,
  output logic        entry_error,
  output logic [7:0]  guess_count,
  output logic        dbg_state
);

  typedef enum logic {
    ENTRY  = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [3:0] MAX_D = 4'(MAX_DIGIT);

  state_t state;

  // A digit arriving in LOCKED is judged against an emptied buffer, so the
  // digit path works from this "base" view rather than the raw registers.
  logic [15:0] base_buf;
  logic [2:0]  base_cnt;
  logic        dup_hit;
  logic        digit_ok;
  logic [15:0] ins_buf;
  logic [15:0] del_buf;

  always_comb begin
    base_buf = entry_buf;
    base_cnt = digit_count;
    if (state == LOCKED) begin
      base_buf = 16'hFFFF;
      base_cnt = 3'd0;
    end

    // Only filled nibbles take part in the duplicate test.
    dup_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) < base_cnt) && (base_buf[(3-i)*4 +: 4] == digit)) begin
        dup_hit = 1'b1;
      end
    end

    digit_ok = (digit <= MAX_D) && (base_cnt != 3'd4) &&
               ((ALLOW_REPEAT != 0) || !dup_hit);

    // The i-th digit entered lives in nibble (3 - i).
    ins_buf = base_buf;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) == base_cnt) begin
        ins_buf[(3-i)*4 +: 4] = digit;
      end
    end

    del_buf = entry_buf;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) + 3'd1) == digit_count) begin
        del_buf[(3-i)*4 +: 4] = 4'hF;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ENTRY;
      entry_buf   <= 16'hFFFF;
      digit_count <= 3'd0;
      guess       <= 16'hFFFF;
      guess_valid <= 1'b0;
      entry_error <= 1'b0;
      guess_count <= 8'd0;
    end else begin
      // Strobes are high only for the cycle after the edge that raised them.
      guess_valid <= 1'b0;
      entry_error <= 1'b0;

      if (enable) begin
        if (clear) begin
          state       <= ENTRY;
          entry_buf   <= 16'hFFFF;
          digit_count <= 3'd0;
        end else if (submit) begin
          if (state == LOCKED) begin
            // A held submit lands here every cycle: errors, never a repeat.
            entry_error <= 1'b1;
          end else if (digit_count == 3'd4) begin
            state       <= LOCKED;
            guess       <= entry_buf;
            guess_valid <= 1'b1;
            if (guess_count != 8'hFF) begin
              guess_count <= guess_count + 8'd1;
            end
          end else begin
            entry_error <= 1'b1;
          end
        end else if (del) begin
          if (state == LOCKED || digit_count == 3'd0) begin
            entry_error <= 1'b1;
          end else begin
            entry_buf   <= del_buf;
            digit_count <= digit_count - 3'd1;
          end
        end else if (digit_valid) begin
          // Leaving LOCKED empties the buffer even if the digit is rejected.
          state <= ENTRY;
          if (digit_ok) begin
            entry_buf   <= ins_buf;
            digit_count <= base_cnt + 3'd1;
          end else begin
            entry_buf   <= base_buf;
            digit_count <= base_cnt;
            entry_error <= 1'b1;
          end
        end
      end
    end
  end

  assign dbg_state = state;

endmodule
